ssp_rx_timeout_ctrl: RTL and testbench

Parametrised receive-timeout detector for the SSP receive path. It generalises the fixed 6-bit, reload-to-31 idle detector. Adds a programmable reload value, a tick prescaler, an enable, a one-cycle event pulse, an interrupt mask and a counter readback. Sits between the Rx FIFO status/sync logic and the interrupt combiner, clocked on SSPCLK.

---
 rtl/ssp_rx_timeout_ctrl.sv | 120 ++++++++++++
 tb/tb_ssp_rx_timeout_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_timeout_ctrl.sv
// Receive-timeout detector: counts prescaled idle ticks while the Rx FIFO holds data
// and raises a sticky timeout status with a one-cycle event pulse.
module ssp_rx_timeout_ctrl #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             SSPCLK,
  input  logic             nSSPRST,
  input  logic             Enable,
  input  logic             IncRxTimeOut,
  input  logic             MRxRT,
  input  logic             SRxRT,
  input  logic             RNESync,
  input  logic             RTICSync,
  input  logic [CNT_W-1:0] TOReload,
  input  logic [PRE_W-1:0] TOPresc,
  input  logic             RTIMask,
  output logic             DataStp,
  output logic             RTIntr,
  output logic             TOEvent,
  output logic [CNT_W-1:0] TOCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COUNT   = 2'b01,
    TRIGGER = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             data_stp_q, data_stp_d;
  logic             to_event_q, to_event_d;
  logic             del_rtic_q;
  logic             rx_rt;
  logic             rti_clr;

  assign rx_rt   = MRxRT | SRxRT;
  assign rti_clr = RTICSync & ~del_rtic_q;

  // Next-state and counter/prescaler update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    data_stp_d = data_stp_q;
    to_event_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d      = TOReload;
        pre_d      = '0;
        data_stp_d = 1'b0;
        if (Enable && RNESync && !rx_rt) state_d = COUNT;
      end
      COUNT: begin
        if (!Enable || !RNESync) begin
          state_d = IDLE;
          cnt_d   = TOReload;
          pre_d   = '0;
        end else if (rx_rt) begin
          cnt_d = TOReload;
          pre_d = '0;
        end else if (IncRxTimeOut) begin
          // >= rather than == so a live TOPresc decrease cannot strand the prescaler
          if (pre_q >= TOPresc) begin
            pre_d = '0;
            if (cnt_q == '0) begin
              state_d    = TRIGGER;
              data_stp_d = 1'b1;
              to_event_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      TRIGGER: begin
        if (rti_clr || !RNESync || rx_rt || !Enable) begin
          state_d    = IDLE;
          data_stp_d = 1'b0;
          cnt_d      = TOReload;
          pre_d      = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        data_stp_d = 1'b0;
        cnt_d      = TOReload;
        pre_d      = '0;
      end
    endcase
  end

  always_ff @(posedge SSPCLK or negedge nSSPRST) begin
    if (!nSSPRST) begin
      state_q    <= IDLE;
      cnt_q      <= '1;
      pre_q      <= '0;
      data_stp_q <= 1'b0;
      to_event_q <= 1'b0;
      del_rtic_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      data_stp_q <= data_stp_d;
      to_event_q <= to_event_d;
      del_rtic_q <= RTICSync;
    end
  end

  assign DataStp = data_stp_q;
  assign TOEvent = to_event_q;
  assign TOCount = cnt_q;
  assign RTIntr  = data_stp_q & ~RTIMask;

endmodule

// File: tb/tb_ssp_rx_timeout_ctrl.sv
// Scoreboard bench for ssp_rx_timeout_ctrl: tick-count reference model feeds an
// expected-value queue that a posedge monitor drains and compares.
module tb_ssp_rx_timeout_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PRE_W = 4;

  logic             SSPCLK = 1'b0;
  logic             nSSPRST;
  logic             Enable, IncRxTimeOut, MRxRT, SRxRT, RNESync, RTICSync, RTIMask;
  logic [CNT_W-1:0] TOReload;
  logic [PRE_W-1:0] TOPresc;
  logic             DataStp, RTIntr, TOEvent;
  logic [CNT_W-1:0] TOCount;

  ssp_rx_timeout_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .SSPCLK(SSPCLK), .nSSPRST(nSSPRST), .Enable(Enable), .IncRxTimeOut(IncRxTimeOut),
    .MRxRT(MRxRT), .SRxRT(SRxRT), .RNESync(RNESync), .RTICSync(RTICSync),
    .TOReload(TOReload), .TOPresc(TOPresc), .RTIMask(RTIMask),
    .DataStp(DataStp), .RTIntr(RTIntr), .TOEvent(TOEvent), .TOCount(TOCount)
  );

  always #5 SSPCLK = ~SSPCLK;

  typedef struct packed {
    logic             ds;
    logic             ev;
    logic             ri;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;

  // Reference model: mode 0 idle, 1 counting, 2 timed out
  int   m_mode = 0;
  int   m_n    = 0;
  int   m_L    = 0;
  logic m_del  = 1'b0;

  logic [CNT_W-1:0] r_val;
  logic [PRE_W-1:0] p_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model advances over the coming edge and queues expectations
  task automatic cyc(input logic en, input logic rne, input logic mrx, input logic srx,
                     input logic tick, input logic rtic, input logic mask);
    logic rxrt, clr, ev;
    int   per;
    exp_t e;
    @(negedge SSPCLK);
    Enable = en; RNESync = rne; MRxRT = mrx; SRxRT = srx; IncRxTimeOut = tick;
    RTICSync = rtic; RTIMask = mask; TOReload = r_val; TOPresc = p_val;
    rxrt = mrx | srx;
    clr  = rtic & ~m_del;
    ev   = 1'b0;
    per  = (m_L + 1) * (int'(p_val) + 1);
    case (m_mode)
      0: begin
        m_L = int'(r_val); m_n = 0;
        if (en && rne && !rxrt) m_mode = 1;
      end
      1: begin
        if (!en || !rne) begin
          m_mode = 0; m_L = int'(r_val); m_n = 0;
        end else if (rxrt) begin
          m_L = int'(r_val); m_n = 0;
        end else if (tick) begin
          m_n++;
          if (m_n == per) begin m_mode = 2; ev = 1'b1; end
        end
      end
      default: begin
        if (clr || !rne || rxrt || !en) begin
          m_mode = 0; m_L = int'(r_val); m_n = 0;
        end
      end
    endcase
    m_del = rtic;
    e.ds  = (m_mode == 2);
    e.ev  = ev;
    e.ri  = (m_mode == 2) & ~mask;
    e.cnt = (m_mode == 2) ? '0 : CNT_W'(m_L - m_n / (int'(p_val) + 1));
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_datastp"}, 32'(DataStp), 32'd0);
    chk({tag, "_toevent"}, 32'(TOEvent), 32'd0);
    chk({tag, "_rtintr"},  32'(RTIntr),  32'd0);
    chk({tag, "_tocount"}, 32'(TOCount), 32'((1 << CNT_W) - 1));
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge
  task automatic do_reset(input string tag);
    @(negedge SSPCLK);
    #2 nSSPRST = 1'b0;
    #1 chk_reset_vals(tag);
    @(posedge SSPCLK);
    #2 nSSPRST = 1'b1;
    m_mode = 0; m_n = 0; m_L = 0; m_del = 1'b0;
  endtask

  task automatic ticks(input int n, input logic rtic, input logic mask);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rtic, mask);
  endtask

  // Monitor: one registered output set per edge, compared against the queued model result
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge SSPCLK);
      #1;
      cycle_no++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({DataStp, TOEvent, RTIntr, TOCount} !== e) begin
          errors++;
          $display("FAIL sb_cycle%0d: got ds=%b ev=%b ri=%b cnt=%0d expected ds=%b ev=%b ri=%b cnt=%0d",
                   cycle_no, DataStp, TOEvent, RTIntr, TOCount, e.ds, e.ev, e.ri, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    logic rtic_lvl, en, rne, mrx, srx, tk;
    int   wait_cnt;
    nSSPRST = 1'b0;
    Enable = 0; IncRxTimeOut = 0; MRxRT = 0; SRxRT = 0; RNESync = 0; RTICSync = 0; RTIMask = 0;
    r_val = 8'd3; p_val = 4'd0; TOReload = r_val; TOPresc = p_val;
    repeat (2) @(negedge SSPCLK);
    chk_reset_vals("por");
    @(posedge SSPCLK);
    #2 nSSPRST = 1'b1;

    // Basic timeout: reload 3, every-cycle ticks
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(6, 1'b0, 1'b0);

    // Prescaled: reload 2, prescale 2, tick every other cycle, mask then unmask
    r_val = 8'd2; p_val = 4'd2;
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 1'(i % 2), 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Reload beats a same-cycle tick at count 1
    r_val = 8'd3; p_val = 4'd0;
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(2, 1'b0, 1'b0);
    cyc(1, 1, 1, 0, 1, 0, 0);
    ticks(5, 1'b0, 1'b0);

    // Held-high clear acts once; retrigger while still high; toggle clears again
    ticks(13, 1'b1, 1'b0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Exit TRIGGER on RNESync low; leave COUNT on Enable low
    ticks(5, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(1, 1'b0, 1'b0);
    r_val = 8'd5;
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Async reset mid-COUNT and mid-TRIGGER
    r_val = 8'd3;
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(2, 1'b0, 1'b0);
    do_reset("rst_count");
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(5, 1'b0, 1'b0);
    do_reset("rst_trigger");

    // Zero reload: first tick times out
    r_val = 8'd0; p_val = 4'd0;
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    ticks(3, 1'b0, 1'b0);

    // Randomised segments; prescale only changes while forced idle
    rtic_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 80 == 0) begin
        r_val = CNT_W'($urandom_range(0, 5));
        p_val = PRE_W'($urandom_range(0, 3));
        cyc(0, 1, 0, 0, 0, rtic_lvl, 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 99) < 8) rtic_lvl = ~rtic_lvl;
        if ($urandom_range(0, 99) < 5) r_val = CNT_W'($urandom_range(0, 5));
        en  = ($urandom_range(0, 99) >= 1);
        rne = ($urandom_range(0, 99) >= 2);
        mrx = ($urandom_range(0, 99) < 1);
        srx = ($urandom_range(0, 99) < 1);
        tk  = ($urandom_range(0, 99) < 70);
        cyc(en, rne, mrx, srx, tk, rtic_lvl, 1'($urandom_range(0, 1)));
      end
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge SSPCLK);
      wait_cnt++;
    end
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
